rs_pool: RTL and testbench



---
 rtl/rs_pool_if.sv | 48 ++++
 rtl/rs_pool.sv | 166 ++++++++++++++++
 tb/tb_rs_pool.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pool_if.sv
// Handshake and broadcast bundle between dispatch/CDB/FU and the reservation station.
// The master side drives dispatch, CDB, ROB head, flush and FU ready.
interface rs_pool_if #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned TAG_W       = 5,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned PAYLOAD_W   = 64,
   parameter int unsigned NUM_CDB     = 2,
   parameter int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1)
);
   logic                       dp_valid;
   logic                       dp_ready;
   logic [TAG_W-1:0]           dp_rob_tag;
   logic                       dp_src1_rdy;
   logic                       dp_src2_rdy;
   logic [TAG_W-1:0]           dp_src1_tag;
   logic [TAG_W-1:0]           dp_src2_tag;
   logic [XLEN-1:0]            dp_src1_val;
   logic [XLEN-1:0]            dp_src2_val;
   logic [PAYLOAD_W-1:0]       dp_payload;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
   logic [NUM_CDB*XLEN-1:0]    cdb_val;
   logic [TAG_W-1:0]           rob_head;
   logic                       flush_valid;
   logic [TAG_W-1:0]           flush_tag;
   logic                       iss_valid;
   logic                       iss_ready;
   logic [TAG_W-1:0]           iss_rob_tag;
   logic [XLEN-1:0]            iss_src1;
   logic [XLEN-1:0]            iss_src2;
   logic [PAYLOAD_W-1:0]       iss_payload;
   logic [CNT_W-1:0]           free_count;

   modport master (
      output dp_valid, dp_rob_tag, dp_src1_rdy, dp_src2_rdy, dp_src1_tag, dp_src2_tag,
             dp_src1_val, dp_src2_val, dp_payload, cdb_valid, cdb_tag, cdb_val, rob_head,
             flush_valid, flush_tag, iss_ready,
      input  dp_ready, iss_valid, iss_rob_tag, iss_src1, iss_src2, iss_payload, free_count
   );

   modport slave (
      input  dp_valid, dp_rob_tag, dp_src1_rdy, dp_src2_rdy, dp_src1_tag, dp_src2_tag,
             dp_src1_val, dp_src2_val, dp_payload, cdb_valid, cdb_tag, cdb_val, rob_head,
             flush_valid, flush_tag, iss_ready,
      output dp_ready, iss_valid, iss_rob_tag, iss_src1, iss_src2, iss_payload, free_count
   );
endinterface

// File: rtl/rs_pool.sv
// Age-ordered reservation station: captures operands from dispatch or the CDBs and
// issues the oldest operand-ready entry; ages are taken relative to the ROB head.
module rs_pool #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned TAG_W       = 5,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned PAYLOAD_W   = 64,
   parameter int unsigned NUM_CDB     = 2,
   parameter int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
   input logic      clock,
   input logic      reset,
   rs_pool_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] busy_q, busy_d;
   logic [NUM_ENTRIES-1:0] rdy1_q, rdy1_d;
   logic [NUM_ENTRIES-1:0] rdy2_q, rdy2_d;
   logic [TAG_W-1:0]       rob_tag_q [NUM_ENTRIES];
   logic [TAG_W-1:0]       rob_tag_d [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag1_q    [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag1_d    [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag2_q    [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag2_d    [NUM_ENTRIES];
   logic [XLEN-1:0]        val1_q    [NUM_ENTRIES];
   logic [XLEN-1:0]        val1_d    [NUM_ENTRIES];
   logic [XLEN-1:0]        val2_q    [NUM_ENTRIES];
   logic [XLEN-1:0]        val2_d    [NUM_ENTRIES];
   logic [PAYLOAD_W-1:0]   payload_q [NUM_ENTRIES];
   logic [PAYLOAD_W-1:0]   payload_d [NUM_ENTRIES];
   logic [CNT_W-1:0]       free_count_q, free_count_d;

   // {hit, value} from the lowest-numbered valid bus carrying the tag
   function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0]         tag,
                                                input logic [NUM_CDB-1:0]       valid,
                                                input logic [NUM_CDB*TAG_W-1:0] tags,
                                                input logic [NUM_CDB*XLEN-1:0]  vals);
      logic [XLEN:0] res;
      res = '0;
      for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
         if (valid[k] && (tags[k*TAG_W +: TAG_W] == tag)) res = {1'b1, vals[k*XLEN +: XLEN]};
      end
      return res;
   endfunction

   // Oldest-ready select works purely on registered state and the ROB head.
   logic [TAG_W-1:0] slot_age [NUM_ENTRIES];
   logic [TAG_W-1:0] sel_age;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_found;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         slot_age[i] = rob_tag_q[i] - bus.rob_head;
         if (busy_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_found || (slot_age[i] < sel_age))) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = slot_age[i];
         end
      end
   end

   assign bus.iss_valid   = sel_found;
   assign bus.iss_rob_tag = sel_found ? rob_tag_q[sel_idx] : '0;
   assign bus.iss_src1    = sel_found ? val1_q[sel_idx]    : '0;
   assign bus.iss_src2    = sel_found ? val2_q[sel_idx]    : '0;
   assign bus.iss_payload = sel_found ? payload_q[sel_idx] : '0;
   assign bus.free_count  = free_count_q;
   assign bus.dp_ready    = (free_count_q != '0);

   logic [XLEN:0]    dp_hit1, dp_hit2, wk1, wk2;
   logic [TAG_W-1:0] flush_age;
   logic [IDX_W-1:0] alloc_idx;
   logic             alloc_found;

   assign dp_hit1   = cdb_lookup(bus.dp_src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
   assign dp_hit2   = cdb_lookup(bus.dp_src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
   assign flush_age = bus.flush_tag - bus.rob_head;

   always_comb begin
      busy_d      = busy_q;
      rdy1_d      = rdy1_q;
      rdy2_d      = rdy2_q;
      rob_tag_d   = rob_tag_q;
      tag1_d      = tag1_q;
      tag2_d      = tag2_q;
      val1_d      = val1_q;
      val2_d      = val2_q;
      payload_d   = payload_q;
      wk1         = '0;
      wk2         = '0;
      alloc_found = 1'b0;
      alloc_idx   = '0;

      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         wk1 = cdb_lookup(tag1_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         wk2 = cdb_lookup(tag2_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         if (!rdy1_q[i] && wk1[XLEN]) begin
            rdy1_d[i] = 1'b1;
            val1_d[i] = wk1[XLEN-1:0];
         end
         if (!rdy2_q[i] && wk2[XLEN]) begin
            rdy2_d[i] = 1'b1;
            val2_d[i] = wk2[XLEN-1:0];
         end
         if (bus.flush_valid && (slot_age[i] > flush_age)) busy_d[i] = 1'b0;
      end

      if (sel_found && bus.iss_ready) busy_d[sel_idx] = 1'b0;

      // Allocation looks at busy_q so slots freed this edge are not reused yet.
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
      end

      if (bus.dp_valid && bus.dp_ready && !bus.flush_valid && alloc_found) begin
         busy_d[alloc_idx]    = 1'b1;
         rob_tag_d[alloc_idx] = bus.dp_rob_tag;
         payload_d[alloc_idx] = bus.dp_payload;
         tag1_d[alloc_idx]    = bus.dp_src1_tag;
         tag2_d[alloc_idx]    = bus.dp_src2_tag;
         rdy1_d[alloc_idx]    = bus.dp_src1_rdy | dp_hit1[XLEN];
         rdy2_d[alloc_idx]    = bus.dp_src2_rdy | dp_hit2[XLEN];
         val1_d[alloc_idx]    = bus.dp_src1_rdy ? bus.dp_src1_val : dp_hit1[XLEN-1:0];
         val2_d[alloc_idx]    = bus.dp_src2_rdy ? bus.dp_src2_val : dp_hit2[XLEN-1:0];
      end

      free_count_d = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (!busy_d[i]) free_count_d = free_count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q       <= '0;
         rdy1_q       <= '0;
         rdy2_q       <= '0;
         rob_tag_q    <= '{default: '0};
         tag1_q       <= '{default: '0};
         tag2_q       <= '{default: '0};
         val1_q       <= '{default: '0};
         val2_q       <= '{default: '0};
         payload_q    <= '{default: '0};
         free_count_q <= CNT_W'(NUM_ENTRIES);
      end else begin
         busy_q       <= busy_d;
         rdy1_q       <= rdy1_d;
         rdy2_q       <= rdy2_d;
         rob_tag_q    <= rob_tag_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         val1_q       <= val1_d;
         val2_q       <= val2_d;
         payload_q    <= payload_d;
         free_count_q <= free_count_d;
      end
   end
endmodule

// File: tb/tb_rs_pool.sv
// Bench for rs_pool: directed scenarios plus a randomized run against a queue-based
// model that picks the oldest ready entry by ROB age.
module tb_rs_pool;
   localparam int N  = 8;
   localparam int TW = 5;
   localparam int XL = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rs_pool_if bus ();
   rs_pool dut (.clock(clock), .reset(reset), .bus(bus));

   typedef struct {
      logic [4:0]  tag;
      logic        r1;
      logic [4:0]  t1;
      logic [31:0] v1;
      logic        r2;
      logic [4:0]  t2;
      logic [31:0] v2;
      logic [63:0] pl;
   } ent_t;

   ent_t mq[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   m_acc;

   function automatic logic [4:0] age(input logic [4:0] t);
      return t - bus.rob_head;
   endfunction

   function automatic int m_sel();
      int best = -1;
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].r1 && mq[i].r2 && (best < 0 || age(mq[i].tag) < age(mq[best].tag))) best = i;
      return best;
   endfunction

   function automatic logic [133:0] m_out();
      int s = m_sel();
      if (s < 0) return '0;
      return {1'b1, mq[s].tag, mq[s].v1, mq[s].v2, mq[s].pl};
   endfunction

   function automatic ent_t wake(input ent_t e);
      ent_t r = e;
      for (int k = 0; k < 2; k++) begin
         if (!r.r1 && bus.cdb_valid[k] && bus.cdb_tag[k*TW +: TW] == r.t1) begin
            r.r1 = 1'b1; r.v1 = bus.cdb_val[k*XL +: XL];
         end
         if (!r.r2 && bus.cdb_valid[k] && bus.cdb_tag[k*TW +: TW] == r.t2) begin
            r.r2 = 1'b1; r.v2 = bus.cdb_val[k*XL +: XL];
         end
      end
      return r;
   endfunction

   task automatic idle();
      bus.dp_valid = 0; bus.dp_rob_tag = 0; bus.dp_src1_rdy = 0; bus.dp_src2_rdy = 0;
      bus.dp_src1_tag = 0; bus.dp_src2_tag = 0; bus.dp_src1_val = 0; bus.dp_src2_val = 0;
      bus.dp_payload = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_val = 0;
      bus.flush_valid = 0; bus.flush_tag = 0; bus.iss_ready = 0;
   endtask

   task automatic disp(input logic [4:0] tag, input logic r1, input logic [4:0] t1,
                       input logic [31:0] v1, input logic r2, input logic [4:0] t2,
                       input logic [31:0] v2);
      bus.dp_valid = 1; bus.dp_rob_tag = tag;
      bus.dp_src1_rdy = r1; bus.dp_src1_tag = t1; bus.dp_src1_val = v1;
      bus.dp_src2_rdy = r2; bus.dp_src2_tag = t2; bus.dp_src2_val = v2;
      bus.dp_payload = {$urandom, $urandom};
   endtask

   task automatic bcast(input int k, input logic [4:0] t, input logic [31:0] v);
      bus.cdb_valid[k] = 1'b1;
      bus.cdb_tag[k*TW +: TW] = t;
      bus.cdb_val[k*XL +: XL] = v;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic step();
      int   s, pre;
      ent_t e;
      @(posedge clock);
      pre   = mq.size();
      s     = m_sel();
      m_acc = 0;
      if (s >= 0 && bus.iss_ready) mq.delete(s);
      if (bus.flush_valid)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (age(mq[i].tag) > age(bus.flush_tag)) mq.delete(i);
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (bus.dp_valid && !bus.flush_valid && pre < N) begin
         e.tag = bus.dp_rob_tag; e.pl = bus.dp_payload;
         e.r1 = bus.dp_src1_rdy; e.t1 = bus.dp_src1_tag; e.v1 = bus.dp_src1_rdy ? bus.dp_src1_val : 0;
         e.r2 = bus.dp_src2_rdy; e.t2 = bus.dp_src2_tag; e.v2 = bus.dp_src2_rdy ? bus.dp_src2_val : 0;
         mq.push_back(wake(e));
         m_acc = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bus.rob_head = 0;
      #12;
      n_checks++;
      if (bus.iss_valid !== 1'b0 || bus.free_count !== 4'd8 || bus.dp_ready !== 1'b1 ||
          bus.iss_rob_tag !== 5'd0 || bus.iss_src1 !== 32'd0 || bus.iss_payload !== 64'd0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b free=%0d rdy=%b tag=%0d, want 0/8/1/0",
                  bus.iss_valid, bus.free_count, bus.dp_ready, bus.iss_rob_tag);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      idle(); bus.rob_head = 0;
      disp(3, 1, 0, 32'h11, 1, 0, 32'h22); bus.iss_ready = 1;
      step();
      idle(); bus.iss_ready = 1;
      n_checks++;
      if ({bus.iss_valid, bus.iss_rob_tag, bus.iss_src1, bus.iss_src2} !== {1'b1, 5'd3, 32'h11, 32'h22}) begin
         n_err++;
         $display("FAIL basic_issue: got v=%b tag=%0d s1=%h s2=%h, want 1/3/11/22",
                  bus.iss_valid, bus.iss_rob_tag, bus.iss_src1, bus.iss_src2);
      end
      step();
      n_checks++;
      if (bus.free_count !== 4'd8 || bus.iss_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_free: got free=%0d v=%b, want 8/0", bus.free_count, bus.iss_valid);
      end
   endtask

   task automatic test_wakeup();
      idle(); bus.rob_head = 0; bus.iss_ready = 1;
      disp(5, 0, 9, 0, 1, 0, 32'h55);
      step();
      bus.dp_valid = 0;
      step();
      n_checks++;
      if (bus.iss_valid !== 1'b0) begin
         n_err++; $display("FAIL wake_wait: got v=%b, want 0", bus.iss_valid);
      end
      bcast(1, 9, 32'hAB);
      step();
      bus.cdb_valid = 0;
      n_checks++;
      if ({bus.iss_valid, bus.iss_rob_tag, bus.iss_src1} !== {1'b1, 5'd5, 32'hAB}) begin
         n_err++;
         $display("FAIL wake_cdb: got v=%b tag=%0d s1=%h, want 1/5/ab",
                  bus.iss_valid, bus.iss_rob_tag, bus.iss_src1);
      end
      step();
      disp(6, 0, 9, 0, 1, 0, 32'h66); bcast(1, 9, 32'hCD);
      step();
      idle(); bus.iss_ready = 1;
      n_checks++;
      if ({bus.iss_valid, bus.iss_rob_tag, bus.iss_src1} !== {1'b1, 5'd6, 32'hCD}) begin
         n_err++;
         $display("FAIL wake_bypass: got v=%b tag=%0d s1=%h, want 1/6/cd",
                  bus.iss_valid, bus.iss_rob_tag, bus.iss_src1);
      end
      step();
      disp(7, 0, 10, 0, 0, 10, 0);
      step();
      idle(); bus.iss_ready = 1;
      bcast(0, 10, 32'h1); bcast(1, 10, 32'h2);
      step();
      bus.cdb_valid = 0;
      n_checks++;
      if ({bus.iss_valid, bus.iss_rob_tag, bus.iss_src1, bus.iss_src2} !== {1'b1, 5'd7, 32'h1, 32'h1}) begin
         n_err++;
         $display("FAIL wake_low_bus: got v=%b tag=%0d s1=%h s2=%h, want 1/7/1/1",
                  bus.iss_valid, bus.iss_rob_tag, bus.iss_src1, bus.iss_src2);
      end
      step();
   endtask

   task automatic test_wrap();
      logic [4:0] want [3] = '{5'd31, 5'd0, 5'd1};
      idle(); bus.rob_head = 30;
      disp(1, 1, 0, 1, 1, 0, 1); step();
      disp(31, 1, 0, 2, 1, 0, 2); step();
      disp(0, 1, 0, 3, 1, 0, 3); step();
      idle();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.iss_valid !== 1'b1 || bus.iss_rob_tag !== want[i]) begin
            n_err++;
            $display("FAIL wrap_order[%0d]: got v=%b tag=%0d, want tag %0d",
                     i, bus.iss_valid, bus.iss_rob_tag, want[i]);
         end
         bus.iss_ready = 1;
         step();
      end
   endtask

   task automatic test_full();
      idle(); bus.rob_head = 0;
      for (int i = 0; i < N; i++) begin
         disp(5'(i), 1, 0, 32'(i), 1, 0, 32'(i));
         step();
      end
      idle();
      n_checks++;
      if (bus.dp_ready !== 1'b0 || bus.free_count !== 4'd0) begin
         n_err++;
         $display("FAIL full_state: got rdy=%b free=%0d, want 0/0", bus.dp_ready, bus.free_count);
      end
      disp(8, 1, 0, 32'h8, 1, 0, 32'h8);
      step();
      idle(); bus.iss_ready = 1;
      step();
      n_checks++;
      if (bus.dp_ready !== 1'b1 || bus.free_count !== 4'd1) begin
         n_err++;
         $display("FAIL full_reopen: got rdy=%b free=%0d, want 1/1", bus.dp_ready, bus.free_count);
      end
      for (int i = 1; i < N; i++) begin
         n_checks++;
         if (bus.iss_valid !== 1'b1 || bus.iss_rob_tag !== 5'(i)) begin
            n_err++;
            $display("FAIL full_drain[%0d]: got v=%b tag=%0d", i, bus.iss_valid, bus.iss_rob_tag);
         end
         step();
      end
      n_checks++;
      if (bus.iss_valid !== 1'b0 || bus.free_count !== 4'd8) begin
         n_err++;
         $display("FAIL full_no_ninth: got v=%b free=%0d, want 0/8", bus.iss_valid, bus.free_count);
      end
   endtask

   task automatic test_flush();
      logic [4:0] tags [4] = '{5'd29, 5'd31, 5'd2, 5'd4};
      idle(); bus.rob_head = 28;
      for (int i = 0; i < 4; i++) begin
         disp(tags[i], 0, 20, 0, 1, 0, 32'(tags[i]));
         step();
      end
      idle();
      bus.flush_valid = 1; bus.flush_tag = 31;
      disp(5, 1, 0, 5, 1, 0, 5);
      step();
      idle();
      n_checks++;
      if (bus.free_count !== 4'd6) begin
         n_err++; $display("FAIL flush_count: got free=%0d, want 6", bus.free_count);
      end
      bcast(0, 20, 32'hEE); bus.iss_ready = 1;
      step();
      bus.cdb_valid = 0;
      n_checks++;
      if ({bus.iss_valid, bus.iss_rob_tag, bus.iss_src1} !== {1'b1, 5'd29, 32'hEE}) begin
         n_err++;
         $display("FAIL flush_keep29: got v=%b tag=%0d s1=%h", bus.iss_valid, bus.iss_rob_tag, bus.iss_src1);
      end
      step();
      n_checks++;
      if (bus.iss_valid !== 1'b1 || bus.iss_rob_tag !== 5'd31) begin
         n_err++; $display("FAIL flush_keep31: got v=%b tag=%0d", bus.iss_valid, bus.iss_rob_tag);
      end
      step();
      n_checks++;
      if (bus.iss_valid !== 1'b0 || bus.free_count !== 4'd8) begin
         n_err++;
         $display("FAIL flush_gone: got v=%b free=%0d, want 0/8", bus.iss_valid, bus.free_count);
      end
   endtask

   task automatic test_async_reset();
      idle(); bus.rob_head = 0;
      for (int i = 0; i < 4; i++) begin
         disp(5'(10 + i), 1, 0, 32'(i), 1, 0, 32'(i));
         step();
      end
      idle();
      n_checks++;
      if (bus.iss_valid !== 1'b1 || bus.free_count !== 4'd4) begin
         n_err++;
         $display("FAIL areset_pre: got v=%b free=%0d, want 1/4", bus.iss_valid, bus.free_count);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.iss_valid !== 1'b0 || bus.free_count !== 4'd8 || bus.dp_ready !== 1'b1) begin
         n_err++;
         $display("FAIL areset_now: got v=%b free=%0d rdy=%b, want 0/8/1",
                  bus.iss_valid, bus.free_count, bus.dp_ready);
      end
      mq.delete();
      #1 reset = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [4:0] head, nt;
      logic [133:0] got, exp;
      nt = 0;
      for (int c = 0; c < 600; c++) begin
         idle();
         head = nt;
         if (mq.size() > 0) begin
            head = mq[0].tag;
            for (int i = 1; i < mq.size(); i++) if (age(mq[i].tag) < age(head)) head = mq[i].tag;
         end
         bus.rob_head  = head;
         bus.iss_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 2; k++) if ($urandom_range(0, 1) == 1) bcast(k, 5'($urandom), $urandom);
         if ($urandom_range(0, 19) == 0 && age(nt) != 0) begin
            bus.flush_valid = 1;
            bus.flush_tag   = head + 5'($urandom_range(0, int'(age(nt)) - 1));
         end
         if ($urandom_range(0, 2) != 0 && age(nt) < 31)
            disp(nt, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
         step();
         if (bus.flush_valid) nt = bus.flush_tag + 5'd1;
         else if (m_acc) nt = nt + 5'd1;
         got = {bus.iss_valid, bus.iss_rob_tag, bus.iss_src1, bus.iss_src2, bus.iss_payload};
         exp = m_out();
         n_checks++;
         if (got !== exp) begin
            n_err++; $display("FAIL rand_issue[%0d]: got %h want %h", c, got, exp);
         end
         n_checks++;
         if (bus.free_count !== 4'(N - mq.size()) || bus.dp_ready !== (mq.size() < N)) begin
            n_err++;
            $display("FAIL rand_free[%0d]: got free=%0d rdy=%b want free=%0d",
                     c, bus.free_count, bus.dp_ready, N - mq.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_wrap();
      test_full();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
